param_fifo: RTL and testbench

- Parametrised successor to the CGRA inter-PE data FIFO: synchronous single-clock FIFO with generic data width and power-of-two depth.
- Full valid/ready handshake on both sides; first-word-fall-through registered output.
- Adds occupancy count and programmable almost-full/almost-empty flags for back-pressure lookahead in processing-element links.

---
 rtl/cgra_fifo_pkg.sv | 16 +
 rtl/param_fifo_if.sv | 38 +++
 rtl/fifo_ram.sv | 37 +++
 rtl/param_fifo.sv | 113 +++++++++++
 tb/tb_param_fifo.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cgra_fifo_pkg.sv
// rtl/cgra_fifo_pkg.sv - shared defaults and clog2 helper for the CGRA FIFO family
package cgra_fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - producer/consumer handshake bundle; PARAM_FIFO_STATUS_EN adds sticky status
interface param_fifo_if import cgra_fifo_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic [DATA_W-1:0] io_din;
    logic              io_din_v;
    logic              io_din_r;
    logic [DATA_W-1:0] io_dout;
    logic              io_dout_v;
    logic              io_dout_r;
    logic [CW-1:0]     io_count;
    logic              io_almost_full;
    logic              io_almost_empty;
`ifdef PARAM_FIFO_STATUS_EN
    logic              io_overflow;
    logic              io_underflow;
`endif

    modport master (
        output io_din, io_din_v, io_dout_r,
        input  io_din_r, io_dout, io_dout_v, io_count, io_almost_full, io_almost_empty
`ifdef PARAM_FIFO_STATUS_EN
        , input io_overflow, io_underflow
`endif
    );

    modport slave (
        input  io_din, io_din_v, io_dout_r,
        output io_din_r, io_dout, io_dout_v, io_count, io_almost_full, io_almost_empty
`ifdef PARAM_FIFO_STATUS_EN
        , output io_overflow, io_underflow
`endif
    );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W dual-port storage, sync write, registered read
module fifo_ram import cgra_fifo_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first on address collision so a word written this cycle can be read out at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - FWFT single-clock FIFO with count and almost flags; PARAM_FIFO_STATUS_EN adds overflow/underflow
module param_fifo import cgra_fifo_pkg::*; #(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic clock,
    input  logic reset,
    param_fifo_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_din_r;
    logic              r_dout_v;
    logic              r_af;
    logic              r_ae;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_next;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rdata;

    assign w_push = bus.io_din_v & r_din_r;
    assign w_pop  = r_dout_v & bus.io_dout_r;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // The RAM read register is the output stage: refill it with the new head on pop or on first push
    assign w_rd_en   = (w_pop && (w_count_next != '0)) || (w_push && (r_count == '0));
    assign w_rd_addr = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.io_din),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_din_r  <= 1'b1;
            r_dout_v <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_next;
            r_din_r  <= (w_count_next < CW'(DEPTH));
            r_dout_v <= (w_count_next != '0);
            r_af     <= (w_count_next >= CW'(AF_LEVEL));
            r_ae     <= (w_count_next <= CW'(AE_LEVEL));
        end
    end

    assign bus.io_din_r        = r_din_r;
    assign bus.io_dout         = w_rdata;
    assign bus.io_dout_v       = r_dout_v;
    assign bus.io_count        = r_count;
    assign bus.io_almost_full  = r_af;
    assign bus.io_almost_empty = r_ae;

`ifdef PARAM_FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.io_din_v && !r_din_r) begin
                r_overflow <= 1'b1;
            end
            if (bus.io_dout_r && !r_dout_v) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.io_overflow  = r_overflow;
    assign bus.io_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo (DEPTH=4, AF_LEVEL=2, AE_LEVEL=1)
module tb_param_fifo;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    param_fifo_if #(.DATA_W(32), .DEPTH(4)) bus ();

    param_fifo #(
        .DATA_W   (32),
        .DEPTH    (4),
        .AF_LEVEL (2),
        .AE_LEVEL (1)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {din_v, dout_r} in, {din_r, dout_v, almost_full, almost_empty} expected
    typedef struct {
        logic [1:0]  in_ctl;
        logic [31:0] din;
        logic [3:0]  e_flags;
        logic [31:0] e_dout;
        logic [2:0]  e_count;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] status();
        return {bus.io_din_r, bus.io_dout_v, bus.io_almost_full, bus.io_almost_empty,
                bus.io_count, bus.io_dout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.io_din_v  = 1'b0;
        bus.io_dout_r = 1'b0;
        bus.io_din    = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        do_reset();
        check("reset_state", status(), {4'b1001, 3'd0, 32'h0});
`ifdef PARAM_FIFO_STATUS_EN
        check("reset_status", {bus.io_overflow, bus.io_underflow}, 2'b00);
`endif

        // First-word latency and hold under back-pressure
        bus.io_din = 32'hA5A5_0001;
        bus.io_din_v = 1'b1;
        tick();
        bus.io_din_v = 1'b0;
        check("first_word", status(), {4'b1101, 3'd1, 32'hA5A5_0001});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_word", status(), {4'b1101, 3'd1, 32'hA5A5_0001});
        end

        do_reset();
        vecs.push_back('{2'b10, 32'h11, 4'b1101, 32'h11, 3'd1});
        vecs.push_back('{2'b10, 32'h22, 4'b1110, 32'h11, 3'd2});
        vecs.push_back('{2'b11, 32'h33, 4'b1110, 32'h22, 3'd2});
        vecs.push_back('{2'b01, 32'h00, 4'b1101, 32'h33, 3'd1});
        vecs.push_back('{2'b11, 32'h44, 4'b1101, 32'h44, 3'd1});
        vecs.push_back('{2'b01, 32'h00, 4'b1001, 32'h44, 3'd0});
        vecs.push_back('{2'b01, 32'h00, 4'b1001, 32'h44, 3'd0});
        vecs.push_back('{2'b11, 32'h55, 4'b1101, 32'h55, 3'd1});
        vecs.push_back('{2'b10, 32'h66, 4'b1110, 32'h55, 3'd2});
        vecs.push_back('{2'b10, 32'h77, 4'b1110, 32'h55, 3'd3});
        vecs.push_back('{2'b10, 32'h88, 4'b0110, 32'h55, 3'd4});
        vecs.push_back('{2'b10, 32'h99, 4'b0110, 32'h55, 3'd4});
        vecs.push_back('{2'b11, 32'h99, 4'b1110, 32'h66, 3'd3});
        vecs.push_back('{2'b10, 32'h99, 4'b0110, 32'h66, 3'd4});
        vecs.push_back('{2'b01, 32'h00, 4'b1110, 32'h77, 3'd3});
        vecs.push_back('{2'b01, 32'h00, 4'b1110, 32'h88, 3'd2});
        vecs.push_back('{2'b01, 32'h00, 4'b1101, 32'h99, 3'd1});
        vecs.push_back('{2'b01, 32'h00, 4'b1001, 32'h99, 3'd0});
        foreach (vecs[i]) begin
            bus.io_din_v  = vecs[i].in_ctl[1];
            bus.io_dout_r = vecs[i].in_ctl[0];
            bus.io_din    = vecs[i].din;
            tick();
            check($sformatf("vec%0d", i), status(),
                  {vecs[i].e_flags, vecs[i].e_count, vecs[i].e_dout});
        end
`ifdef PARAM_FIFO_STATUS_EN
        check("sticky_status", {bus.io_overflow, bus.io_underflow}, 2'b11);
`endif

        // Continuous streaming through the pointer wrap
        do_reset();
        got.delete();
        for (int i = 0; i < 13; i++) begin
            bus.io_din_v  = (i < 12);
            bus.io_din    = 32'h10 + 32'(i);
            bus.io_dout_r = 1'b1;
            if (i > 0) begin
                check("stream_valid", bus.io_dout_v, 1'b1);
            end
            if (bus.io_dout_v) begin
                got.push_back(bus.io_dout);
            end
            tick();
            if (i < 12) begin
                check("stream_count", bus.io_count, 3'd1);
            end
        end
        check("stream_len", got.size(), 12);
        foreach (got[k]) begin
            check("stream_data", got[k], 32'h10 + 32'(k));
        end

        // Asynchronous reset with three words held
        bus.io_dout_r = 1'b0;
        bus.io_din_v  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.io_din = 32'hC0 + 32'(i);
            tick();
        end
        bus.io_din_v = 1'b0;
        tick();
        check("pre_reset", status(), {4'b1110, 3'd3, 32'hC0});
        #2 rst = 1'b1;
        #1;
        check("async_reset", status(), {4'b1001, 3'd0, 32'h0});
        #10 rst = 1'b0;
        tick();
        check("post_reset", status(), {4'b1001, 3'd0, 32'h0});

        // Random traffic against a scoreboard
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            logic push;
            logic pop;
            bus.io_din_v  = 1'($urandom_range(0, 1));
            bus.io_dout_r = 1'($urandom_range(0, 1));
            bus.io_din    = $urandom;
            check("rnd_valid", bus.io_dout_v, sb.size() != 0);
            check("rnd_ready", bus.io_din_r, sb.size() < 4);
            push = bus.io_din_v & bus.io_din_r;
            pop  = bus.io_dout_v & bus.io_dout_r;
            if (pop && sb.size() > 0) begin
                check("rnd_data", bus.io_dout, sb[0]);
                void'(sb.pop_front());
            end
            if (push) begin
                sb.push_back(bus.io_din);
            end
            tick();
            check("rnd_count", bus.io_count, sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
